// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared state encoding and display/op constants for the ALU op sequencer
package alu_seq_pkg;
    typedef enum logic [1:0] {IDLE, OPND, RES} state_t;
    localparam logic DISP_OPND = 1'b1;
    localparam logic DISP_RES = 1'b0;
    localparam logic [1:0] OP_FIRST = 2'd0;
    localparam logic [1:0] OP_LAST = 2'd3;
endpackage

// File: rtl/alu_op_sequencer_hold_timer.sv
// hold_timer: phase timer that pulses expire on the last cycle of each HOLD_CYCLES-long phase
// ports: clk, rst (sync, active-high), clear (reload for a new phase), en (phase running), expire (last-cycle pulse)
module hold_timer #(
    parameter int HOLD_CYCLES = 1000,
    localparam int CNT_W = $clog2(HOLD_CYCLES + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic expire
);
    localparam logic [CNT_W-1:0] LOAD = CNT_W'(HOLD_CYCLES - 1);
    logic [CNT_W-1:0] cnt;
    always_ff @(posedge clk) begin
        if (rst) cnt <= '0;
        else if (clear) cnt <= LOAD;
        else if (en && cnt != '0) cnt <= cnt - 1'b1;
    end
    assign expire = en && cnt == '0;
endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: latches operands on start and steps the ALU/display through one or all four ops
// ports: clk, rst (sync, active-high), start/abort/mode/loop/op_in/a_in/b_in (requests and operands),
//        alu_a/alu_b/alu_sel (ALU drive), disp_sel (1 = operand view), busy, done (end-of-pass pulse)
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int HOLD_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic       mode,
    input  logic       loop,
    input  logic [1:0] op_in,
    input  logic [2:0] a_in,
    input  logic [2:0] b_in,
    output logic [2:0] alu_a,
    output logic [2:0] alu_b,
    output logic [1:0] alu_sel,
    output logic       disp_sel,
    output logic       busy,
    output logic       done
);
    state_t state;
    logic mode_q, loop_q, expire;
    // Idle keeps the timer preloaded so the first phase after start is full length
    hold_timer #(.HOLD_CYCLES(HOLD_CYCLES)) u_timer (
        .clk(clk),
        .rst(rst),
        .clear(state == IDLE || abort || expire),
        .en(state != IDLE),
        .expire(expire)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            mode_q <= 1'b0;
            loop_q <= 1'b0;
            alu_a <= '0;
            alu_b <= '0;
            alu_sel <= OP_FIRST;
            disp_sel <= DISP_RES;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (start && !abort) begin
                    state <= OPND;
                    mode_q <= mode;
                    loop_q <= loop;
                    alu_a <= a_in;
                    alu_b <= b_in;
                    alu_sel <= mode ? OP_FIRST : op_in;
                    disp_sel <= DISP_OPND;
                    busy <= 1'b1;
                end
            end else if (abort) begin
                state <= IDLE;
                busy <= 1'b0;
            end else if (expire) begin
                if (state == OPND) begin
                    state <= RES;
                    disp_sel <= DISP_RES;
                end else if (mode_q && alu_sel != OP_LAST) begin
                    state <= OPND;
                    alu_sel <= alu_sel + 1'b1;
                    disp_sel <= DISP_OPND;
                end else begin
                    done <= 1'b1;
                    if (loop_q) begin
                        // scan wraps OP_LAST -> OP_FIRST naturally; single keeps its op
                        state <= OPND;
                        alu_sel <= mode_q ? alu_sel + 1'b1 : alu_sel;
                        disp_sel <= DISP_OPND;
                    end else begin
                        state <= IDLE;
                        busy <= 1'b0;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: directed-vector self-checking bench for alu_op_sequencer with HOLD_CYCLES=3
module tb_alu_op_sequencer;
    logic clk = 1'b0;
    logic rst, start, abort, mode, loop;
    logic [1:0] op_in, alu_sel;
    logic [2:0] a_in, b_in, alu_a, alu_b;
    logic disp_sel, busy, done;
    int checks = 0;
    int failures = 0;

    alu_op_sequencer #(.HOLD_CYCLES(3)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .mode(mode), .loop(loop),
        .op_in(op_in), .a_in(a_in), .b_in(b_in), .alu_a(alu_a), .alu_b(alu_b),
        .alu_sel(alu_sel), .disp_sel(disp_sel), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input int a, input int b, input int sel,
                           input int disp, input int bsy, input int dn);
        chk($sformatf("%s.alu_a", tag), 8'(alu_a), 8'(a));
        chk($sformatf("%s.alu_b", tag), 8'(alu_b), 8'(b));
        chk($sformatf("%s.alu_sel", tag), 8'(alu_sel), 8'(sel));
        chk($sformatf("%s.disp_sel", tag), 8'(disp_sel), 8'(disp));
        chk($sformatf("%s.busy", tag), 8'(busy), 8'(bsy));
        chk($sformatf("%s.done", tag), 8'(done), 8'(dn));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic kick(input logic m, input logic l, input logic [1:0] op, input logic [2:0] a, input logic [2:0] b);
        mode = m; loop = l; op_in = op; a_in = a; b_in = b;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic run_single(input int a, input int b, input int op);
        kick(1'b0, 1'b0, 2'(op), 3'(a), 3'(b));
        for (int c = 1; c <= 8; c++) begin
            chk_out($sformatf("single c%0d", c), a, b, op, int'(c <= 3), int'(c <= 6), int'(c == 7));
            if (c < 8) tick();
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; mode = 1'b0; loop = 1'b0;
        op_in = '0; a_in = '0; b_in = '0;
        tick(); tick();
        chk_out("reset", 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        tick();
        chk_out("idle", 0, 0, 0, 0, 0, 0);

        run_single(5, 3, 2);

        // scan with a start pulse mid-run that must be ignored
        kick(1'b1, 1'b0, 2'd0, 3'd7, 3'd1);
        for (int c = 1; c <= 26; c++) begin
            chk_out($sformatf("scan c%0d", c), 7, 1, c <= 24 ? (c - 1) / 6 : 3,
                    c <= 24 ? int'(((c - 1) % 6) < 3) : 0, int'(c <= 24), int'(c == 25));
            if (c == 10) begin start = 1'b1; a_in = 3'd0; op_in = 2'd1; mode = 1'b0; end
            if (c == 11) begin start = 1'b0; a_in = 3'd7; mode = 1'b1; end
            if (c < 26) tick();
        end

        // abort during the second op of a scan
        kick(1'b1, 1'b0, 2'd0, 3'd7, 3'd1);
        for (int c = 1; c <= 8; c++) begin
            chk_out($sformatf("abort_pre c%0d", c), 7, 1, (c - 1) / 6, int'(((c - 1) % 6) < 3), 1, 0);
            if (c == 8) abort = 1'b1;
            tick();
        end
        abort = 1'b0;
        for (int c = 9; c <= 12; c++) begin
            chk_out($sformatf("abort_post c%0d", c), 7, 1, 1, 1, 0, 0);
            tick();
        end
        run_single(2, 4, 3);

        // looping scan: loop is latched, so dropping it after start has no effect
        kick(1'b1, 1'b1, 2'd0, 3'd6, 3'd2);
        loop = 1'b0;
        for (int c = 1; c <= 50; c++) begin
            chk_out($sformatf("loop c%0d", c), 6, 2, ((c - 1) % 24) / 6,
                    int'((((c - 1) % 24) % 6) < 3), 1, int'(c == 25 || c == 49));
            if (c == 50) abort = 1'b1;
            tick();
        end
        abort = 1'b0;
        chk_out("loop_abort", 6, 2, 0, 1, 0, 0);

        // reset in the middle of a single op, then start masked by abort
        kick(1'b0, 1'b0, 2'd2, 3'd5, 3'd3);
        for (int c = 1; c < 5; c++) tick();
        chk_out("rst_pre c5", 5, 3, 2, 0, 1, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_out("rst_post c6", 0, 0, 0, 0, 0, 0);
        tick();
        abort = 1'b1;
        kick(1'b0, 1'b0, 2'd1, 3'd4, 3'd4);
        abort = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            chk_out($sformatf("start_abort c%0d", c), 0, 0, 0, 0, 0, 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
